// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: RV32M multiply/divide unit, one bit per cycle.
// Shift-add multiply and restoring divide run on operand magnitudes.
// The result is negated at the end when the operand signs call for it.
// Divide-by-zero and signed divide overflow finish one cycle after acceptance.
// Optional feature macro: ALU_MULDIV_FAST_MUL_EN. When defined, all four
// multiply ops use a combinational 2*XLEN product and finish in one cycle.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. out_valid is high only in
// DONE, and result stays stable there until the edge where out_ready is high.
// flush cancels any accepted or held operation on the next edge, with no
// transfer. flush wins over in_valid and out_ready in the same cycle.
module alu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [1:0]      dbg_state_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q;
    logic [2:0]          f3_q;
    logic                neg_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     a_q;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q;     // mul: {hi, multiplier}; div: low half is dividend/quotient
    logic [XLEN-1:0]     rem_q;     // partial remainder
    logic [XLEN-1:0]     result_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    // Decode of the incoming request: operand signs, magnitudes, fast-path cases
    logic            is_div;
    logic            op1_signed;
    logic            op2_signed;
    logic            s1;
    logic            s2;
    logic            neg_in;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN-1:0] fast_div_res;

    // Classify the operation presented on the input port
    always_comb begin
        is_div       = funct3[2];
        op1_signed   = is_div ? ~funct3[0] : (funct3 != 3'b011);
        op2_signed   = is_div ? ~funct3[0] : ~funct3[1];
        s1           = op1_signed & op1[XLEN-1];
        s2           = op2_signed & op2[XLEN-1];
        mag1         = s1 ? (-op1) : op1;
        mag2         = s2 ? (-op2) : op2;
        // Remainder takes the dividend's sign, everything else the XOR of both
        neg_in       = (is_div && funct3[1]) ? s1 : (s1 ^ s2);
        div_zero     = is_div && (op2 == '0);
        div_ovf      = is_div && !funct3[0] &&
                       (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        if (div_zero) begin
            fast_div_res = funct3[1] ? op1 : '1;
        end else begin
            fast_div_res = funct3[1] ? '0 : op1;
        end
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_mag;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_mul_res;

    // Single-cycle product of the magnitudes, sign restored afterwards
    always_comb begin
        fast_prod_mag = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        fast_prod     = neg_in ? (-fast_prod_mag) : fast_prod_mag;
        fast_mul_res  = (funct3 == 3'b000) ? fast_prod[XLEN-1:0]
                                           : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // One iteration of each datapath, plus its final signed result
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc_d;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_rsh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   div_rem_d;
    logic [XLEN-1:0]   div_quo_d;
    logic [XLEN-1:0]   div_res;

    // Shift-add step and restoring-divide step
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
        mul_prod  = neg_q ? (-mul_acc_d) : mul_acc_d;
        mul_res   = (f3_q == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

        // Partial remainder is XLEN+1 bits wide after the shift; the kept
        // remainder always fits XLEN bits since it is below the divisor.
        div_rsh   = {rem_q, acc_q[XLEN-1]};
        div_ge    = (div_rsh >= {1'b0, a_q});
        div_diff  = div_rsh[XLEN-1:0] - a_q;
        div_rem_d = div_ge ? div_diff : div_rsh[XLEN-1:0];
        div_quo_d = {acc_q[XLEN-2:0], div_ge};
        if (f3_q[1]) begin
            div_res = neg_q ? (-div_rem_d) : div_rem_d;
        end else begin
            div_res = neg_q ? (-div_quo_d) : div_quo_d;
        end
    end

    // Control FSM and datapath registers, with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            f3_q        <= 3'b000;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        f3_q       <= funct3;
                        neg_q      <= neg_in;
                        cnt_q      <= CW'(XLEN - 1);
                        a_q        <= is_div ? mag2 : mag1;
                        acc_q      <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                        rem_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (div_zero || div_ovf) begin
                            state_q     <= S_DONE;
                            result_q    <= fast_div_res;
                            out_valid_q <= 1'b1;
                        end else if (is_div) begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                        end else begin
`ifdef ALU_MULDIV_FAST_MUL_EN
                            state_q     <= S_DONE;
                            result_q    <= fast_mul_res;
                            out_valid_q <= 1'b1;
`else
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
`endif
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    if (cnt_q == '0) begin
                        state_q     <= S_DONE;
                        result_q    <= mul_res;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DIV: begin
                    acc_q <= {acc_q[2*XLEN-1:XLEN], div_quo_d};
                    rem_q <= div_rem_d;
                    if (cnt_q == '0) begin
                        state_q     <= S_DONE;
                        result_q    <= div_res;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Bench for alu_muldiv_iter (XLEN=32): directed RV32M cases with literal
// expectations, fast-path, backpressure, flush and reset cases, then
// randomized operations checked against a 64-bit arithmetic model.
module tb_alu_muldiv_iter;
  localparam int XLEN = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      funct3;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [1:0]      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // scoreboard state
  logic [XLEN-1:0] exp_q[$];
  bit inflight  = 1'b0;
  bit exp_iter  = 1'b0;
  int acc_cyc   = 0;
  int exp_lat   = 0;
  int age       = 0;

  alu_muldiv_iter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op1        (op1),
    .op2        (op2),
    .funct3     (funct3),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: RV32M semantics with 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return FAST_MUL;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // compare process: every cycle, outputs against the scoreboard model
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      inflight = 1'b0;
      exp_q.delete();
    end else begin
      age = cyc - acc_cyc;
      check("in_ready", in_ready, !inflight);
      check("busy", busy, inflight && exp_iter && age >= 1 && age <= XLEN);
      check("out_valid", out_valid, inflight && age >= exp_lat);
      if (out_valid && exp_q.size() > 0) check("result", result, exp_q[0]);
      if (flush) begin
        inflight = 1'b0;
        exp_q.delete();
      end else if (inflight && age >= exp_lat && out_ready) begin
        void'(exp_q.pop_front());
        inflight = 1'b0;
      end else if (!inflight && in_valid) begin
        exp_q.push_back(model(funct3, op1, op2));
        acc_cyc  = cyc;
        exp_iter = !is_fast(funct3, op1, op2);
        exp_lat  = exp_iter ? XLEN + 1 : 1;
        inflight = 1'b1;
      end
    end
  end

  // driver: called at posedge+1; returns at posedge+1 after the output handshake
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit lit_en, input logic [31:0] lit,
                       input string name);
    int waited;
    bit fast;
    fast     = is_fast(f, a, b);
    in_valid = 1'b1;
    op1      = a;
    op2      = b;
    funct3   = f;
    @(posedge clk); #1;
    // scramble inputs after acceptance; in_valid may stay high while busy
    in_valid = 1'($urandom_range(0, 1));
    op1      = $urandom;
    op2      = $urandom;
    funct3   = 3'($urandom_range(0, 7));
    waited   = 0;
    while (!out_valid && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: out_valid low after %0d cycles, required high", name, waited);
      in_valid = 1'b0;
      return;
    end
    check({name, " latency"}, waited + 1, fast ? 1 : XLEN + 1);
    if (lit_en) check(name, result, lit);
    repeat (hold) begin @(posedge clk); #1; end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    op1       = '0;
    op2       = '0;
    funct3    = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset result", result, 0);
    check("reset state", dbg_state, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // directed, literal expectations
    do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 0, 1, 32'hFFFF_FFEB, "MUL 7*-3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 1, 32'h4000_0000, "MULH min*min");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, "MULHU max*max");
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2,        2, 1, 32'hFFFF_FFFF, "MULHSU -1*2");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,        0, 1, 32'hFFFF_FFFD, "DIV -7/2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,        0, 1, 32'hFFFF_FFFF, "REM -7/2");
    do_op(3'd5, 32'd100,      32'd7,         0, 1, 32'd14,        "DIVU 100/7");
    do_op(3'd7, 32'd100,      32'd7,         0, 1, 32'd2,         "REMU 100/7");
    do_op(3'd4, 32'd5,        32'd0,         0, 1, 32'hFFFF_FFFF, "DIV 5/0");
    do_op(3'd6, 32'd5,        32'd0,         0, 1, 32'd5,         "REM 5/0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, "DIV ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h0,         "REM ovf");
    // backpressure, then back-to-back acceptance
    do_op(3'd5, 32'd1000,     32'd9,         5, 1, 32'd111,       "DIVU backpressure");
    do_op(3'd0, 32'd12,       32'd12,        0, 1, 32'd144,       "MUL after handshake");

    // flush at cycle 10 of a divide
    in_valid = 1'b1; op1 = 32'd100; op2 = 32'd7; funct3 = 3'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush no out_valid", seen, 0);

    // asynchronous reset at cycle 20 of a multiply
    in_valid = 1'b1; op1 = 32'd3; op2 = 32'd5; funct3 = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midop reset in_ready", in_ready, 1);
    check("midop reset out_valid", out_valid, 0);
    check("midop reset busy", busy, 0);
    check("midop reset result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(3'd0, 32'd3, 32'd5, 0, 1, 32'd15, "MUL after reset");

    // randomized operations against the model
    for (int i = 0; i < 150; i++) begin
      do_op(3'($urandom_range(0, 7)), rand_val(), rand_val(), $urandom_range(0, 3),
            1'b0, 32'h0, "random");
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_iter.md
# alu_muldiv_iter

Parametrised multi-cycle multiply/divide unit executing the RV32M `funct3` group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over an XLEN-wide datapath. It sits beside the single-cycle arithmetic ALU in the execute stage. It takes operands through a valid/ready handshake, iterates one bit per cycle, and holds the result until the consumer accepts it. Divide-by-zero and signed overflow resolve on a one-cycle fast path.

## Interface
- `XLEN`, default 32: operand and result width; any even value ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock domain, asynchronous assert, active-low.
- `in_valid`  in  1  operands and `funct3` valid.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op1`  in  XLEN  rs1 value (dividend / multiplicand).
- `op2`  in  XLEN  rs2 value (divisor / multiplier).
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `flush`  in  1  synchronous kill of any in-flight or held operation.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer accepts `result`.
- `result`  out  XLEN  operation result.
- `busy`  out  1  high in MUL or DIV state.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: on `in_valid && in_ready`, latch operands and `funct3`, then branch:
  - DIV/REM with `op2`==0 → DONE. Quotient all ones; remainder = `op1`.
  - DIV/REM signed with `op1`==most-negative and `op2`==all ones → DONE. Quotient = `op1`; remainder = 0.
  - Other divide → DIV. Other multiply → MUL, or DONE when the macro below is defined.
- Sign handling:
  - Signed operands (op1 for MUL/MULH/MULHSU/DIV/REM; op2 for MUL/MULH/DIV/REM) are converted to magnitude and a negate flag is recorded.
  - The final value is two's-complement negated when the flag is set.
  - Quotient sign = sign(op1) XOR sign(op2). Remainder sign = sign(op1).
- MUL state: shift-add on a 2·XLEN accumulator with an XLEN-1..0 counter, one multiplier bit per cycle. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DIV state: restoring division, one quotient bit per cycle, XLEN cycles, XLEN+1-bit partial remainder.
- Last iteration → DONE with `result` registered.
- DONE: `out_valid`=1; `result` held stable. On `out_ready` → IDLE.
- `flush`: from any state → IDLE next edge; `out_valid` drops; no result is produced. `flush` takes priority over `in_valid` and `out_ready` in the same cycle.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, counter 0.

## Timing
- Acceptance edge = cycle 0.
- Iterative operation: `busy` high cycles 1..XLEN; `out_valid` rises at cycle XLEN+1 (33 for XLEN=32).
- Fast path (special divide cases, or multiply with the macro): `out_valid` at cycle 1; `busy` never asserts.
- `in_ready` low from cycle 1 until the cycle after the output handshake. No same-cycle output/input overlap.
- `rst_n` low mid-operation clears all state immediately (asynchronous). The first acceptance is possible on the first edge after deassertion.
- `op1`/`op2` may change after acceptance without effect.

## Configuration
- `ALU_MULDIV_FAST_MUL_EN` defined: all four multiply ops use a single-cycle combinational 2·XLEN product. The MUL state is unreachable; latency is 1 cycle. Divide is unchanged.
- Macro undefined: multiply is iterative, XLEN+1 cycle latency; no hardware multiplier is inferred.

## Test plan
XLEN=32, macro undefined unless stated.
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, with `out_valid` exactly at cycle 33. With the macro defined, the same result arrives at cycle 1.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast path, each with `out_valid` at cycle 1 and `busy` never high:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`. `result` stays stable and `in_ready` stays 0. After the handshake, `in_ready`=1 on the next cycle and a new op is accepted.
- Flush and reset:
  - `flush` at cycle 10 of a DIV → `out_valid` never asserts; `in_ready`=1 next cycle.
  - `rst_n` pulsed low at cycle 20 of a MUL → all outputs return to reset values immediately.
